// File: rtl/memory_bank.sv
// memory_bank: parametrised scratch memory built from NUM_COL interleaved
// storage columns. It has a valid/ready request port and a registered read
// response with backpressure. A hardware clear sequence writes RESET_VALUE
// into every element after reset or when clear_i is pulsed.
//
// state | meaning
// INIT  | clear sequence: one row of every column written per cycle
// RUN   | requests serviced, init_done_o high
module memory_bank #(
  parameter int                    ELEM_WIDTH  = 8,
  parameter int                    NUM_COL     = 8,
  parameter int                    COL_DEPTH   = 1024,
  parameter logic [ELEM_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    ADDR_WIDTH  = $clog2(NUM_COL*COL_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [ELEM_WIDTH-1:0] req_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ELEM_WIDTH-1:0] rsp_data_o,
  output logic                  init_done_o
);

  localparam int COL_W = $clog2(NUM_COL);
  localparam int ROW_W = $clog2(COL_DEPTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(COL_DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ELEM_WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic [COL_W-1:0]        req_col;
  logic [ROW_W-1:0]        req_row;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [ELEM_WIDTH-1:0]   col_rd [NUM_COL];

  // Low address bits select the column so consecutive addresses interleave.
  assign req_col = req_addr_i[COL_W-1:0];
  assign req_row = req_addr_i[ADDR_WIDTH-1:COL_W];

  assign accept = req_valid_i && req_ready_o;
  assign wr_acc = accept && req_we_i;
  assign rd_acc = accept && !req_we_i;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    logic [ELEM_WIDTH-1:0] mem_q [COL_DEPTH];
    logic                  we;
    logic [ROW_W-1:0]      wa;
    logic [ELEM_WIDTH-1:0] wd;

    // During INIT every column is written with the clear value at row_q.
    assign we = !rst_i && ((state_q == ST_INIT) ||
                           (wr_acc && (req_col == COL_W'(c))));
    assign wa = (state_q == ST_INIT) ? row_q : req_row;
    assign wd = (state_q == ST_INIT) ? RESET_VALUE : req_data_i;

    // Column storage write port; contents are not reset, INIT clears them.
    always_ff @(posedge clk_i) begin
      if (we) begin
        mem_q[wa] <= wd;
      end
    end

    assign col_rd[c] = mem_q[req_row];
  end

  // Next-state, row counter and handshake outputs of the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    req_ready_o = 1'b0;
    init_done_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (clear_i) begin
          row_d = '0;
        end else if (row_q == LAST_ROW) begin
          state_d = ST_RUN;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_RUN: begin
        init_done_o = 1'b1;
        req_ready_o = !clear_i && (!rsp_valid_q || rsp_ready_i);
        if (clear_i) begin
          state_d = ST_INIT;
          row_d   = '0;
        end
      end
    endcase
  end

  // Response register: a clear drops a pending response, a read reloads it.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if ((state_q == ST_RUN) && clear_i) begin
      rsp_valid_d = 1'b0;
    end else if (rd_acc) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = col_rd[req_col];
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      row_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: doc/memory_bank.md
# memory_bank

- Parametrised successor to the fixed 8-column, 13-bit-address, 8-bit memory page.
- Stores NUM_COL × COL_DEPTH elements of ELEM_WIDTH bits.
- Adds a valid/ready request port, a registered read-response port with backpressure, and a hardware clear sequence after reset or on demand.
- Sits between bus-side request logic and the storage columns; it is the standard on-chip scratch memory for subsystem datapaths.

## Interface
Parameters:
- ELEM_WIDTH, 8, bits per element
- NUM_COL, 8, number of columns; power of two, ≥2
- COL_DEPTH, 1024, elements per column; power of two, ≥2
- RESET_VALUE, '0, value written to every element by the clear sequence
- ADDR_WIDTH, $clog2(NUM_COL*COL_DEPTH) (13 at defaults), derived; not to be overridden

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous request to re-run the clear sequence
- req_valid_i  in  1  request present
- req_ready_o  out  1  request can be accepted this cycle
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  element address
- req_data_i  in  ELEM_WIDTH  write data
- rsp_valid_o  out  1  read data valid
- rsp_ready_i  in  1  consumer takes read data
- rsp_data_o  out  ELEM_WIDTH  read data
- init_done_o  out  1  high once the clear sequence has completed

## Operation
Address decode:
- Column = req_addr_i[$clog2(NUM_COL)-1:0].
- Row = req_addr_i[ADDR_WIDTH-1:$clog2(NUM_COL)].
- Consecutive addresses therefore interleave across columns.

FSM states:
- INIT:
  - A row counter walks 0 to COL_DEPTH-1.
  - Each cycle, RESET_VALUE is written into the current row of all columns.
  - After row COL_DEPTH-1 is written, the FSM goes to RUN.
  - req_ready_o = 0 and init_done_o = 0 throughout INIT.
- RUN:
  - Requests are serviced.
  - init_done_o = 1.
  - clear_i = 1 moves the FSM to INIT with the row counter at 0.

Request handshake:
- A request is accepted on a cycle with req_valid_i && req_ready_o.
- req_ready_o = (state==RUN) && !clear_i && (!rsp_valid_o || rsp_ready_i).
- req_ready_o does not depend on req_valid_i or req_we_i.

Writes:
- On acceptance, req_data_i is stored at the decoded (column, row).
- A write produces no response.

Reads:
- On acceptance, the addressed element is captured into rsp_data_o.
- rsp_valid_o is set on the next edge.

Response handshake:
- A response completes on a cycle with rsp_valid_o && rsp_ready_i.
- rsp_valid_o clears on completion unless a new read is accepted in the same cycle. In that case it stays high and rsp_data_o takes the new data.
- While rsp_valid_o && !rsp_ready_i, rsp_data_o is held stable and no request is accepted.

Clear while a response is pending: rsp_valid_o is dropped on the next edge and that response is lost.

## Timing
Reset:
- rst_i sampled high: next edge gives state INIT, row counter 0, req_ready_o 0, rsp_valid_o 0, rsp_data_o 0, init_done_o 0.
- Reset mid-operation: same result; contents are cleared again by INIT.
- rst_i has priority over clear_i and over requests.

Clear duration:
- Exactly COL_DEPTH cycles in INIT.
- At defaults, rst_i released before edge 0 gives INIT on edges 0..1023; init_done_o and req_ready_o go high after edge 1023.
- clear_i asserted during INIT restarts the row counter at 0.

Read latency:
- Accepted on edge N: rsp_valid_o high and rsp_data_o valid from edge N+1.
- Read-after-write to the same address on consecutive cycles returns the new data.

Throughput: one request per cycle while rsp_ready_i is held high.

Out-of-range rows cannot occur because all parameters are powers of two and the decode is exact.

## Test plan
1. Reset then idle, with RESET_VALUE=8'h00:
   - rst_i pulsed, then requests held: req_ready_o stays 0 for 1024 cycles, then rises with init_done_o.
   - Reads of addresses 0, 7, 8191 return 8'h00.
2. Write then read back:
   - Write 8'hA5 at addr 13'h0009, then 8'h3C at addr 13'h0001.
   - Read 9 returns 8'hA5 one cycle after acceptance; read 1 returns 8'h3C.
   - This confirms column/row interleave with no aliasing.
3. Back-to-back streaming:
   - Write addr k with data k[7:0] for k=0..63, then 64 consecutive reads with rsp_ready_i=1.
   - One response per cycle, data 0..63 in order, no gaps.
4. Backpressure:
   - Read addr 5 (holding 8'h05) with rsp_ready_i=0 for 4 cycles.
   - rsp_valid_o=1 with data 8'h05 held, and req_ready_o=0 for those cycles.
   - rsp_ready_i=1 in the same cycle as a new read of addr 6: the response is replaced by 8'h06 on the next edge, with no bubble.
5. Clear mid-operation:
   - With a response pending and memory non-zero, pulse clear_i.
   - On the next edge rsp_valid_o=0 and init_done_o=0; after 1024 cycles, all addresses read RESET_VALUE.
6. Reset during INIT:
   - Assert rst_i at INIT row 500.
   - The full 1024-cycle clear restarts from row 0, and all outputs are 0 on the edge after reset.
